// File: rtl/traffic_mon_pkg.sv
// traffic_mon_pkg: light encodings, phase codes, legal-pattern table, dwell defaults and monitor states
package traffic_mon_pkg;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] P1 = 3'd0;
  localparam logic [2:0] P2 = 3'd1;
  localparam logic [2:0] P3 = 3'd2;
  localparam logic [2:0] P4 = 3'd3;
  localparam logic [2:0] P5 = 3'd4;
  localparam logic [2:0] P6 = 3'd5;
  localparam logic [2:0] PH_INVALID = 3'd7;
  // patterns are {M1, M2, MT, S}, indexed by phase code
  localparam logic [0:5][11:0] LEGAL_PAT = {
    {GRN, GRN, RED, RED},
    {GRN, YEL, RED, RED},
    {GRN, RED, GRN, RED},
    {YEL, RED, YEL, RED},
    {RED, RED, RED, GRN},
    {RED, RED, RED, YEL}
  };
  localparam int DWELL_P1_DEF = 8;
  localparam int DWELL_P2_DEF = 3;
  localparam int DWELL_P3_DEF = 6;
  localparam int DWELL_P4_DEF = 3;
  localparam int DWELL_P5_DEF = 4;
  localparam int DWELL_P6_DEF = 3;
  typedef enum logic [1:0] {SYNC_WAIT, SYNC_EDGE, TRACK, FAULT} mon_state_t;
  function automatic logic [2:0] next_phase(input logic [2:0] p);
    return p == P6 ? P1 : p + 3'd1;
  endfunction
endpackage

// File: rtl/light_phase_decode.sv
// light_phase_decode: combinational 12-bit light pattern to phase code and validity
module light_phase_decode
  import traffic_mon_pkg::*;
(
  input  logic [11:0] pattern,
  output logic [2:0]  phase,
  output logic        phase_valid
);
  assign phase = pattern == LEGAL_PAT[P1] ? P1 :
                 pattern == LEGAL_PAT[P2] ? P2 :
                 pattern == LEGAL_PAT[P3] ? P3 :
                 pattern == LEGAL_PAT[P4] ? P4 :
                 pattern == LEGAL_PAT[P5] ? P5 :
                 pattern == LEGAL_PAT[P6] ? P6 : PH_INVALID;
  assign phase_valid = phase != PH_INVALID;
endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: snoops the controller's light buses, checks pattern legality, phase order and dwell
// Dwell counter and timing checks are built only when TRAFFIC_MON_TIMING_CHECK_EN is defined.
module traffic_light_monitor
  import traffic_mon_pkg::*;
#(
`ifdef TRAFFIC_MON_TIMING_CHECK_EN
  parameter int DWELL_P1 = DWELL_P1_DEF,
  parameter int DWELL_P2 = DWELL_P2_DEF,
  parameter int DWELL_P3 = DWELL_P3_DEF,
  parameter int DWELL_P4 = DWELL_P4_DEF,
  parameter int DWELL_P5 = DWELL_P5_DEF,
  parameter int DWELL_P6 = DWELL_P6_DEF,
  parameter int CNT_W    = 4,
`endif
  parameter int CYC_W    = 8
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       light_M1,
  input  logic [2:0]       light_M2,
  input  logic [2:0]       light_MT,
  input  logic [2:0]       light_S,
  input  logic             clr_fault,
  output logic [2:0]       phase,
  output logic             phase_valid,
  output logic             err_conflict,
  output logic             err_sequence,
  output logic             err_timing,
  output logic             fault,
  output logic [CYC_W-1:0] cycle_cnt
);
  logic [11:0] light_q;
  logic [2:0]  dec_ph, ref_ph, new_err, err_nxt;
  logic        dec_valid, is_same, is_next, chk_on, clr_now, any_err, e_tim;
  mon_state_t  state;
  // snapshot the buses so decode and checks see one stable pattern per cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) light_q <= '0;
    else light_q <= {light_M1, light_M2, light_MT, light_S};
  light_phase_decode u_dec (.pattern(light_q), .phase(dec_ph), .phase_valid(dec_valid));
  assign is_same = dec_ph == ref_ph;
  assign is_next = dec_ph == next_phase(ref_ph);
`ifdef TRAFFIC_MON_TIMING_CHECK_EN
  logic [CNT_W-1:0] dwell_cnt, dwell_lim;
  logic             at_dwell;
  // overstay fires on one more sample at the limit, early fires on leaving before reaching it
  always_comb begin
    dwell_lim = ref_ph == P1 ? CNT_W'(DWELL_P1) :
                ref_ph == P2 ? CNT_W'(DWELL_P2) :
                ref_ph == P3 ? CNT_W'(DWELL_P3) :
                ref_ph == P4 ? CNT_W'(DWELL_P4) :
                ref_ph == P5 ? CNT_W'(DWELL_P5) : CNT_W'(DWELL_P6);
    at_dwell = dwell_cnt == dwell_lim;
    e_tim = state == TRACK && dec_valid && (is_same ? at_dwell : is_next && !at_dwell);
  end
`else
  assign e_tim = 1'b0;
`endif
  // classify against the last legal phase; an invalid pattern can only raise the conflict bit
  always_comb begin
    chk_on = state != SYNC_WAIT;
    new_err = {chk_on && !dec_valid, chk_on && dec_valid && !is_same && !is_next, e_tim};
    any_err = |new_err;
    clr_now = state == FAULT && clr_fault;
    err_nxt = new_err | (clr_now ? 3'b000 : {err_conflict, err_sequence, err_timing});
  end
  // sync/track/fault sequencing with registered phase, sticky status and cycle count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= SYNC_WAIT;
      ref_ph <= P1;
      phase <= PH_INVALID;
      phase_valid <= 1'b0;
      {err_conflict, err_sequence, err_timing} <= 3'b000;
      fault <= 1'b0;
      cycle_cnt <= '0;
`ifdef TRAFFIC_MON_TIMING_CHECK_EN
      dwell_cnt <= '0;
`endif
    end else begin
      phase <= dec_ph;
      phase_valid <= dec_valid;
      if (dec_valid) ref_ph <= dec_ph;
      {err_conflict, err_sequence, err_timing} <= err_nxt;
      fault <= |err_nxt;
      case (state)
        SYNC_WAIT: if (dec_valid) state <= SYNC_EDGE;
        SYNC_EDGE, TRACK: begin
          if (any_err) state <= FAULT;
          else if (is_next) begin
            state <= TRACK;
            if (state == TRACK && ref_ph == P6) cycle_cnt <= cycle_cnt + 1'b1;
          end
`ifdef TRAFFIC_MON_TIMING_CHECK_EN
          if (!any_err)
            dwell_cnt <= is_next ? CNT_W'(1) :
                         state == TRACK && !(&dwell_cnt) ? dwell_cnt + 1'b1 : dwell_cnt;
`endif
        end
        default: if (clr_now && !any_err) state <= SYNC_WAIT;
      endcase
    end
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: table, directed and random checks of traffic_light_monitor against a reference model
module tb_traffic_light_monitor;
  typedef struct {
    logic [11:0] pat;
    logic [2:0]  ph;
    logic        v;
  } dec_vec_t;

  localparam logic [11:0] LEGAL [6] = '{12'b001_001_100_100, 12'b001_010_100_100, 12'b001_100_001_100,
                                        12'b010_100_010_100, 12'b100_100_100_001, 12'b100_100_100_010};
  localparam int DWELL [6] = '{8, 3, 6, 3, 4, 3};
  localparam logic [11:0] CONF = 12'b001_001_001_100;
  localparam logic [15:0] RESET_VEC = {3'd7, 1'b0, 4'b0000, 8'd0};
`ifdef TRAFFIC_MON_TIMING_CHECK_EN
  localparam logic TIM = 1'b1;
`else
  localparam logic TIM = 1'b0;
`endif

  logic        clk, rst_n, clr_fault;
  logic [11:0] lights;
  logic [2:0]  phase;
  logic        phase_valid, err_conflict, err_sequence, err_timing, fault;
  logic [7:0]  cycle_cnt;
  logic [15:0] dut_vec;
  int          checks = 0, errors = 0, n_step = 0;

  int          m_mode, m_ref, m_run, m_cyc;
  logic        m_ec, m_es, m_et, m_v;
  logic [2:0]  m_ph;
  logic [11:0] m_q;
  dec_vec_t    tbl [9];

  traffic_light_monitor dut (
    .clk(clk), .rst_n(rst_n),
    .light_M1(lights[11:9]), .light_M2(lights[8:6]), .light_MT(lights[5:3]), .light_S(lights[2:0]),
    .clr_fault(clr_fault), .phase(phase), .phase_valid(phase_valid),
    .err_conflict(err_conflict), .err_sequence(err_sequence), .err_timing(err_timing),
    .fault(fault), .cycle_cnt(cycle_cnt)
  );

  assign dut_vec = {phase, phase_valid, err_conflict, err_sequence, err_timing, fault, cycle_cnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, n_step, got, exp);
    end
  endtask

  function automatic logic [15:0] model_vec();
    return {m_ph, m_v, m_ec, m_es, m_et, m_ec | m_es | m_et, 8'(m_cyc)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ref = 0; m_run = 0; m_cyc = 0;
    m_ec = 0; m_es = 0; m_et = 0; m_ph = 3'd7; m_v = 0; m_q = '0;
  endtask

  // modes: 0 waiting for first legal pattern, 1 first phase seen, 2 tracking dwell, 3 faulted
  task automatic model_eval(input logic [11:0] q, input logic clr);
    int  p;
    logic c, s, t;
    p = -1;
    for (int i = 0; i < 6; i++) if (q == LEGAL[i]) p = i;
    c = 0; s = 0; t = 0;
    if (m_mode != 0) begin
      if (p < 0) c = 1;
      else if (p != m_ref && p != (m_ref + 1) % 6) s = 1;
`ifdef TRAFFIC_MON_TIMING_CHECK_EN
      else if (m_mode == 2 && p == m_ref && m_run == DWELL[m_ref]) t = 1;
      else if (m_mode == 2 && p != m_ref && m_run < DWELL[m_ref]) t = 1;
`endif
    end
    if (c || s || t) begin
      if (m_mode == 3 && clr) begin m_ec = c; m_es = s; m_et = t; end
      else begin m_ec |= c; m_es |= s; m_et |= t; end
      m_mode = 3;
    end else if (m_mode == 3) begin
      if (clr) begin m_ec = 0; m_es = 0; m_et = 0; m_mode = 0; end
    end else if (m_mode == 0) begin
      if (p >= 0) m_mode = 1;
    end else if (p != m_ref) begin
      if (m_mode == 2 && m_ref == 5) m_cyc = (m_cyc + 1) % 256;
      m_mode = 2;
      m_run = 1;
    end else m_run++;
    m_ph = p < 0 ? 3'd7 : 3'(p);
    m_v = p >= 0;
    if (p >= 0) m_ref = p;
  endtask

  task automatic step(input logic [11:0] pat, input logic clr);
    lights = pat;
    clr_fault = clr;
    @(posedge clk);
    model_eval(m_q, clr);
    m_q = pat;
    n_step++;
    @(negedge clk);
    check("model", dut_vec, model_vec());
  endtask

  task automatic run_phase(input int p, input int n);
    repeat (n) step(LEGAL[p], 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    lights = '0;
    clr_fault = 1'b0;
    #1;
    check("async_reset", dut_vec, RESET_VEC);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int p, held, len, r;
    logic [11:0] pat;
    logic c;
    rst_n = 1'b1;
    lights = '0;
    clr_fault = 1'b0;
    @(negedge clk);

    // nominal sequence three times
    do_reset();
    repeat (3) for (int k = 0; k < 6; k++) run_phase(k, DWELL[k]);
    check("nominal_cyc", cycle_cnt, 32'd2);
    check("nominal_err", {err_conflict, err_sequence, err_timing, fault}, 32'd0);
    step(LEGAL[0], 1'b0);
    check("latency_p6", phase, 32'd5);
    step(LEGAL[0], 1'b0);
    check("latency_p1", phase, 32'd0);
    check("cyc_after_p1", cycle_cnt, 32'd3);

    // P3 overstay
    do_reset();
    run_phase(0, 8); run_phase(1, 3); run_phase(2, 7);
    check("overstay_pre", err_timing, 32'd0);
    step(LEGAL[2], 1'b0);
    check("overstay_tim", err_timing, 32'(TIM));
    check("overstay_fault", fault, 32'(TIM));

    // P2 too short
    do_reset();
    run_phase(0, 8); run_phase(1, 2); run_phase(2, 1);
    step(LEGAL[2], 1'b0);
    check("early_tim", err_timing, 32'(TIM));

    // P1 -> P3 jump while tracking, then clear
    do_reset();
    for (int k = 0; k < 6; k++) run_phase(k, DWELL[k]);
    run_phase(0, 3); run_phase(2, 2);
    check("jump_seq", err_sequence, 32'd1);
    check("jump_tim", err_timing, 32'd0);
    step(LEGAL[2], 1'b1);
    check("clr_bits", {err_conflict, err_sequence, err_timing, fault}, 32'd0);
    step(LEGAL[2], 1'b0);
    check("clr_resync", fault, 32'd0);

    // conflicting greens, clear racing a repeated conflict
    do_reset();
    run_phase(0, 3);
    step(CONF, 1'b0); step(CONF, 1'b0);
    check("conf_err", {err_conflict, err_sequence, err_timing}, 32'b100);
    check("conf_phase", {phase, phase_valid}, {3'd7, 1'b0});
    step(CONF, 1'b1);
    check("conf_clr_race", err_conflict, 32'd1);
    step(CONF, 1'b0);
    check("conf_sticky", fault, 32'd1);

    // dark lights while waiting, sync on P4, then fault and reset mid-P5
    do_reset();
    repeat (5) step(12'h000, 1'b0);
    check("wait_dark", fault, 32'd0);
    run_phase(3, 3); run_phase(4, 2);
    step(LEGAL[4], 1'b0);
    check("p4_p5_ok", {err_conflict, err_sequence, err_timing, fault}, 32'd0);
    run_phase(1, 2);
    check("p5_p2_seq", {err_sequence, fault}, 32'b11);
    run_phase(4, 2);
    #2;
    do_reset();

    // decode table
    tbl[0] = '{12'b001_001_100_100, 3'd0, 1'b1};
    tbl[1] = '{12'b001_010_100_100, 3'd1, 1'b1};
    tbl[2] = '{12'b001_100_001_100, 3'd2, 1'b1};
    tbl[3] = '{12'b010_100_010_100, 3'd3, 1'b1};
    tbl[4] = '{12'b100_100_100_001, 3'd4, 1'b1};
    tbl[5] = '{12'b100_100_100_010, 3'd5, 1'b1};
    tbl[6] = '{12'b100_100_100_100, 3'd7, 1'b0};
    tbl[7] = '{12'b011_001_100_100, 3'd7, 1'b0};
    tbl[8] = '{12'b010_010_100_100, 3'd7, 1'b0};
    for (int k = 0; k < 9; k++) begin
      step(tbl[k].pat, 1'b0);
      step(tbl[k].pat, 1'b0);
      check("decode", {phase, phase_valid}, {tbl[k].ph, tbl[k].v});
    end

    // random walk around the nominal sequence with glitches, jumps, clears and resets
    do_reset();
    p = 0; held = 0; len = DWELL[0];
    for (int k = 0; k < 1500; k++) begin
      r = int'($urandom_range(0, 199));
      c = $urandom_range(0, 19) == 0;
      if (r == 0) begin
        do_reset();
        p = 0; held = 0; len = DWELL[0];
      end else begin
        if (r < 6) pat = 12'($urandom);
        else if (r < 11) pat = LEGAL[$urandom_range(0, 5)];
        else begin
          pat = LEGAL[p];
          held++;
          if (held >= len) begin
            held = 0;
            p = (p + 1) % 6;
            len = DWELL[p] + ($urandom_range(0, 9) == 0 ? int'($urandom_range(0, 2)) - 1 : 0);
          end
        end
        step(pat, c);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Independent checker on the receiving end of the controller's four light buses (M1, M2, MT, S). Decodes each sampled pattern into a phase.
- Verifies the legal phase order P1→P2→P3→P4→P5→P6→P1, the per-phase dwell times and pattern legality.
- Reports sticky fault status that board logic uses to force all-red. Sits beside the controller and snoops its outputs.

Parameters:
- DWELL_P1, 8, cycles P1 must persist (P2 3, P3 6, P4 3, P5 4, P6 3: parameters DWELL_P2..DWELL_P6).
- CNT_W, 4, width of the dwell counter; saturates at all-ones.
- CYC_W, 8, width of the completed-cycle counter; wraps.

Ports:
- clk  in  1  rising-edge clock, same clock as the controller
- rst_n  in  1  asynchronous, active-low reset
- light_M1, light_M2, light_MT, light_S  in  3 each  observed lights; 100 red, 010 yellow, 001 green
- clr_fault  in  1  single-cycle pulse; clears sticky errors and re-arms the monitor
- phase  out  3  decoded phase 0..5 = P1..P6; 7 = invalid
- phase_valid  out  1  sampled pattern is one of the six legal patterns
- err_conflict, err_sequence, err_timing  out  1 each  sticky error bits
- fault  out  1  OR of the three error bits
- cycle_cnt  out  CYC_W  number of completed P6→P1 transitions; wraps

Behaviour:
- Reset: asynchronous on rst_n low.
  - Outputs: phase=7, phase_valid=0, all error bits 0, fault=0, cycle_cnt=0.
  - Internal: input register 0, dwell counter 0, state SYNC_WAIT.
- Input stage: the four buses are registered each cycle (light_q).
  - Decode and checks run on light_q.
  - All outputs are registered. A pattern present before edge N shows on phase, phase_valid and the error bits after edge N+1.
- Legal patterns as {M1,M2,MT,S}:
  - P1 {001,001,100,100}
  - P2 {001,010,100,100}
  - P3 {001,100,001,100}
  - P4 {010,100,010,100}
  - P5 {100,100,100,001}
  - P6 {100,100,100,010}
  - Anything else is invalid, including non-one-hot buses.
- SYNC_WAIT: invalid patterns are ignored. On the first legal pattern: record phase, go to SYNC_EDGE.
- SYNC_EDGE:
  - Invalid pattern → err_conflict.
  - Same phase → stay; no timing check.
  - Phase change to next(old) → TRACK, dwell counter = 1.
  - Phase change to any other phase → err_sequence.
- TRACK:
  - Same phase → counter increments (saturating). If the counter already equals DWELL of that phase → err_timing (overstay).
  - Change to next(old) with counter == DWELL(old) → legal; counter = 1. If old is P6, cycle_cnt increments.
  - Change to next(old) with counter < DWELL(old) → err_timing (early).
  - Change to a non-successor → err_sequence.
  - Invalid pattern → err_conflict.
- FAULT:
  - Entered on any error. Error bits are sticky and fault=1.
  - Further errors OR into the status. Checking continues; the dwell counter is frozen.
  - phase and phase_valid keep tracking the input.
- clr_fault:
  - From FAULT: clears all error bits and goes to SYNC_WAIT.
  - In any other state: no effect.
- Simultaneous clr_fault and new error: the error wins. Status becomes only the new error bit(s); the state stays FAULT.
- Multiple errors in one cycle: conflict takes precedence over sequence and timing. Only err_conflict is set.
- Reset mid-operation: immediate return to reset values. No partial state survives.

Optional Feature:
- Macro TRAFFIC_MON_TIMING_CHECK_EN.
- Defined: dwell counter and timing checks present as above.
- Undefined:
  - Dwell counter removed; err_timing tied 0.
  - A phase change to the successor is always legal regardless of dwell.
  - Sequence and conflict checks are unchanged.

Decomposition:
- Package traffic_mon_pkg holds:
  - light encodings RED/YEL/GRN
  - phase codes P1..P6 and PH_INVALID
  - the legal-pattern constant table
  - default dwell values
  - the state enum SYNC_WAIT/SYNC_EDGE/TRACK/FAULT
- Sub-module light_phase_decode: combinational, 12-bit pattern → {phase, phase_valid}. Reusable by the controller's own testbench.

Test Plan:
- Reset, then drive the controller's nominal sequence P1×8, P2×3, P3×6, P4×3, P5×4, P6×3 repeated 3 times → no error bits set; cycle_cnt=2 after the third P1 entry; phase tracks with 2-cycle latency.
- After sync, hold P3 for 7 cycles → err_timing=1 and fault=1 two cycles after the 7th P3 sample. Hold P2 for only 2 cycles before P3 → err_timing=1.
- In TRACK, jump P1→P3 → err_sequence=1, err_timing=0. Then pulse clr_fault → all bits 0, state SYNC_WAIT.
- Drive {001,001,001,100} (M1 green with MT green) → err_conflict=1, phase=7, phase_valid=0. Assert clr_fault in the same cycle as a second invalid pattern → err_conflict stays 1.
- After reset, drive all-zero lights for 5 cycles, then P4 → no error while waiting; then P4→P5 → TRACK with no timing error.
- Assert rst_n low mid-P5 with fault=1 → all outputs return to reset values asynchronously. Build without TRAFFIC_MON_TIMING_CHECK_EN and rerun scenario 2 → err_timing stays 0.
